// File: rtl/cbfp_block_normalizer.sv
// Block-floating-point output normaliser for the FFT CBFP stage.
//
// Collects one block of BEATS input beats into a local buffer and tracks the
// minimum per-group shift count seen anywhere in the block. When the last
// beat arrives, that minimum becomes the block exponent m. The block is then
// drained with one common shift s = REF_SHIFT - m applied to every sample,
// with optional round-half-up and optional saturation to DOUT_W bits.
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clr         synchronous abort of the partial or draining block
//   valid_in    input beat valid; ready_in is high while filling
//   cal_cnt     GROUPS signed shift counts for the beat, group g at [g*CNT_W +: CNT_W]
//   din         LANES signed samples, lane l at [l*DIN_W +: DIN_W]
//   valid_out   output beat valid; ready_out is the downstream accept
//   dout        LANES normalised samples, lane l at [l*DOUT_W +: DOUT_W]
//   blk_exp     signed block minimum count m, constant for the block
//   last_out    marks the final beat of the block
module cbfp_block_normalizer #(
  parameter int CNT_W     = 5,
  parameter int DIN_W     = 23,
  parameter int DOUT_W    = 11,
  parameter int LANES     = 16,
  parameter int GROUPS    = 4,
  parameter int BEATS     = 4,
  parameter int REF_SHIFT = 12,
  parameter bit ROUND_EN  = 1'b1,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [GROUPS*CNT_W-1:0] cal_cnt,
  input  logic [LANES*DIN_W-1:0]  din,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [LANES*DOUT_W-1:0] dout,
  output logic [CNT_W-1:0]        blk_exp,
  output logic                    last_out
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(BEATS - 1);

  // Wide enough for the largest left shift plus sign, and for the rounding
  // add on right shifts, so nothing wraps before saturation.
  localparam int WW = DIN_W + 2**(CNT_W-1) + 1;

  localparam logic signed [CNT_W-1:0] CntMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W:0]   RefShift = (CNT_W+1)'(REF_SHIFT);
  localparam logic signed [WW-1:0]    SatMax = {{(WW-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0]    SatMin = {{(WW-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                    state_q;
  logic [CW-1:0]             wr_cnt_q;
  logic [CW-1:0]             rd_cnt_q;
  logic signed [CNT_W-1:0]   run_min_q;
  logic                      ready_in_q;
  logic                      valid_out_q;
  logic                      last_out_q;
  logic [LANES*DOUT_W-1:0]   dout_q;
  logic signed [CNT_W-1:0]   blk_exp_q;

  logic [LANES*DIN_W-1:0]    buf_q [BEATS];

  logic                      in_hs;
  logic                      out_hs;
  logic signed [CNT_W-1:0]   min_next;
  logic [CW-1:0]             rd_idx;
  logic [LANES*DIN_W-1:0]    src;
  logic signed [CNT_W-1:0]   norm_m;
  logic [LANES*DOUT_W-1:0]   norm_out;

  assign in_hs  = valid_in && ready_in_q;
  assign out_hs = valid_out_q && ready_out;

  assign ready_in  = ready_in_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign dout      = dout_q;
  assign blk_exp   = blk_exp_q;

  // One sample through the common shift, rounding and output clamp.
  function automatic logic [DOUT_W-1:0] norm_sample(input logic [DIN_W-1:0] x,
                                                    input logic [CNT_W-1:0] m);
    logic signed [CNT_W:0] s;
    logic signed [WW-1:0]  v;
    logic signed [WW-1:0]  half;
    int                    sh;
    s  = RefShift - $signed({m[CNT_W-1], m});
    v  = {{(WW-DIN_W){x[DIN_W-1]}}, x};
    sh = int'(s);
    if (sh > 0) begin
      // Shifting past DIN_W only replicates the sign, so cap it there.
      if (sh > DIN_W) sh = DIN_W;
      if (ROUND_EN) begin
        half = {{(WW-1){1'b0}}, 1'b1} << (sh - 1);
        v    = v + half;
      end
      v = v >>> sh;
    end else begin
      v = v <<< (-sh);
    end
    if (SAT_EN) begin
      if (v > SatMax) begin
        v = SatMax;
      end else if (v < SatMin) begin
        v = SatMin;
      end
    end
    return v[DOUT_W-1:0];
  endfunction

  // Running minimum including the beat currently on the input.
  always_comb begin
    logic signed [CNT_W-1:0] cnt_g;
    min_next = run_min_q;
    for (int g = 0; g < GROUPS; g++) begin
      cnt_g = $signed(cal_cnt[g*CNT_W +: CNT_W]);
      if (cnt_g < min_next) min_next = cnt_g;
    end
  end

  // The normaliser feeds the output register. While filling it prepares beat 0
  // with the freshly updated minimum so the first output appears one cycle
  // after the last input; while draining it prepares the beat after rd_cnt.
  always_comb begin
    rd_idx = '0;
    if (state_q == StDrain && rd_cnt_q != LastIdx) rd_idx = rd_cnt_q + CW'(1);
    // With a single beat the block's only beat is still on din when it completes.
    src      = (BEATS == 1) ? din : buf_q[rd_idx];
    norm_m   = (state_q == StFill) ? min_next : blk_exp_q;
    norm_out = '0;
    for (int l = 0; l < LANES; l++) begin
      norm_out[l*DOUT_W +: DOUT_W] = norm_sample(src[l*DIN_W +: DIN_W], norm_m);
    end
  end

  // Sample storage carries no reset; its contents only matter once written.
  always_ff @(posedge clk) begin
    if (in_hs && !clr) buf_q[wr_cnt_q] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      run_min_q   <= CntMax;
      ready_in_q  <= 1'b0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      dout_q      <= '0;
      blk_exp_q   <= '0;
    end else if (clr) begin
      state_q     <= StFill;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      run_min_q   <= CntMax;
      ready_in_q  <= 1'b1;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      case (state_q)
        StFill: begin
          ready_in_q <= 1'b1;
          if (in_hs) begin
            if (wr_cnt_q == LastIdx) begin
              state_q     <= StDrain;
              wr_cnt_q    <= '0;
              rd_cnt_q    <= '0;
              run_min_q   <= CntMax;
              ready_in_q  <= 1'b0;
              blk_exp_q   <= min_next;
              dout_q      <= norm_out;
              valid_out_q <= 1'b1;
              last_out_q  <= (LastIdx == '0);
            end else begin
              wr_cnt_q  <= wr_cnt_q + CW'(1);
              run_min_q <= min_next;
            end
          end
        end
        StDrain: begin
          if (out_hs) begin
            if (rd_cnt_q == LastIdx) begin
              state_q     <= StFill;
              rd_cnt_q    <= '0;
              ready_in_q  <= 1'b1;
              valid_out_q <= 1'b0;
              last_out_q  <= 1'b0;
            end else begin
              rd_cnt_q   <= rd_cnt_q + CW'(1);
              dout_q     <= norm_out;
              last_out_q <= ((rd_cnt_q + CW'(1)) == LastIdx);
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_cbfp_block_normalizer.sv
// Directed bench for cbfp_block_normalizer with default parameters. A second
// instance with rounding disabled shares all inputs for the truncation cases.
module tb_cbfp_block_normalizer;

  localparam int CNT_W  = 5;
  localparam int DIN_W  = 23;
  localparam int DOUT_W = 11;
  localparam int LANES  = 16;
  localparam int GROUPS = 4;
  localparam int BEATS  = 4;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic                    clr;
  logic                    valid_in;
  logic                    ready_out;
  logic [GROUPS*CNT_W-1:0] cal_cnt;
  logic [LANES*DIN_W-1:0]  din;

  logic                    ready_in, valid_out, last_out;
  logic [LANES*DOUT_W-1:0] dout;
  logic [CNT_W-1:0]        blk_exp;

  logic                    ready_in_nr, valid_out_nr, last_out_nr;
  logic [LANES*DOUT_W-1:0] dout_nr;
  logic [CNT_W-1:0]        blk_exp_nr;

  cbfp_block_normalizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .cal_cnt   (cal_cnt),
    .din       (din),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .dout      (dout),
    .blk_exp   (blk_exp),
    .last_out  (last_out)
  );

  cbfp_block_normalizer #(.ROUND_EN(1'b0)) dut_nr (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .valid_in  (valid_in),
    .ready_in  (ready_in_nr),
    .cal_cnt   (cal_cnt),
    .din       (din),
    .valid_out (valid_out_nr),
    .ready_out (ready_out),
    .dout      (dout_nr),
    .blk_exp   (blk_exp_nr),
    .last_out  (last_out_nr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [LANES*DIN_W-1:0]  blk_din [BEATS];
  logic [GROUPS*CNT_W-1:0] blk_cnt [BEATS];
  int                      exp_out [BEATS][4];
  int                      exp_m;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [LANES*DOUT_W-1:0] d, input int l);
    logic signed [DOUT_W-1:0] v;
    v = d[l*DOUT_W +: DOUT_W];
    return int'(v);
  endfunction

  function automatic int sexp(input logic [CNT_W-1:0] e);
    logic signed [CNT_W-1:0] v;
    v = e;
    return int'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int b, input int l, input int val, input int ex);
    blk_din[b][l*DIN_W +: DIN_W] = DIN_W'(val);
    if (l < 4) exp_out[b][l] = ex;
  endtask

  task automatic set_cnt(input int b, input int g, input int val);
    blk_cnt[b][g*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic clear_block(input int cnt);
    for (int b = 0; b < BEATS; b++) begin
      blk_din[b] = '0;
      for (int g = 0; g < GROUPS; g++) set_cnt(b, g, cnt);
      for (int l = 0; l < 4; l++) exp_out[b][l] = 0;
    end
    exp_m = cnt;
  endtask

  task automatic send_block(input int nbeats);
    int n;
    for (int b = 0; b < nbeats; b++) begin
      din      = blk_din[b];
      cal_cnt  = blk_cnt[b];
      valid_in = 1'b1;
      n = 0;
      while (!ready_in && n < 20) begin
        step();
        n++;
      end
      if (!ready_in) check_eq("ready_in_timeout", 0, 1);
      check_eq($sformatf("no_early_valid_b%0d", b), valid_out, 0);
      step();
    end
    valid_in = 1'b0;
    din      = '0;
  endtask

  // Expects the first beat to be presented already (one cycle after the last input).
  task automatic recv_block(input string tag);
    for (int b = 0; b < BEATS; b++) begin
      check_eq($sformatf("%s_valid_b%0d", tag, b), valid_out, 1);
      check_eq($sformatf("%s_rdyin_b%0d", tag, b), ready_in, 0);
      check_eq($sformatf("%s_exp_b%0d", tag, b), sexp(blk_exp), exp_m);
      check_eq($sformatf("%s_last_b%0d", tag, b), last_out, (b == BEATS - 1));
      for (int l = 0; l < 4; l++) begin
        check_eq($sformatf("%s_b%0d_l%0d", tag, b, l), lane(dout, l), exp_out[b][l]);
      end
      step();
    end
    check_eq({tag, "_valid_after"}, valid_out, 0);
    check_eq({tag, "_rdyin_after"}, ready_in, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn      = 1'b0;
    clr       = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    cal_cnt   = '0;
    din       = '0;
    #12;
    check_eq("rst_ready_in", ready_in, 0);
    check_eq("rst_valid_out", valid_out, 0);
    check_eq("rst_last_out", last_out, 0);
    check_eq("rst_blk_exp", sexp(blk_exp), 0);
    check_eq("rst_dout", (dout == '0), 1);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check_eq("post_rst_ready_in", ready_in, 1);

    // Unit shift: all counts at the reference.
    clear_block(12);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 1000, 1000);
    send_block(BEATS);
    recv_block("t1");

    // Minimum taken across beats: one group in beat 2 drops to 9.
    clear_block(12);
    set_cnt(1, 1, 9);
    exp_m = 9;
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 800, 100);
    send_block(BEATS);
    recv_block("t2");

    // Rounding at s=2; the truncating instance sees the same beats.
    clear_block(10);
    for (int b = 0; b < BEATS; b++) begin
      set_lane(b, 0, 6, 2);
      set_lane(b, 1, -6, -1);
      set_lane(b, 2, 1000, 250);
    end
    send_block(BEATS);
    check_eq("t3_nr_valid", valid_out_nr, 1);
    check_eq("t3_nr_l0", lane(dout_nr, 0), 1);
    check_eq("t3_nr_l1", lane(dout_nr, 1), -2);
    check_eq("t3_nr_l2", lane(dout_nr, 2), 250);
    recv_block("t3");

    // Saturation at unit shift.
    clear_block(12);
    for (int b = 0; b < BEATS; b++) begin
      set_lane(b, 0, 4000, 1023);
      set_lane(b, 1, -4000, -1024);
      set_lane(b, 2, 1023, 1023);
      set_lane(b, 3, -1024, -1024);
    end
    send_block(BEATS);
    recv_block("t4sat");

    // Left shift by 2.
    clear_block(14);
    for (int b = 0; b < BEATS; b++) begin
      set_lane(b, 0, 100, 400);
      set_lane(b, 1, 4000, 1023);
      set_lane(b, 2, -3, -12);
    end
    send_block(BEATS);
    recv_block("t4left");

    // Backpressure for 3 cycles on output beat 2.
    clear_block(12);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 100 * (b + 1), 100 * (b + 1));
    send_block(BEATS);
    check_eq("t5_b0", lane(dout, 0), 100);
    step();
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_hold_valid_%0d", i), valid_out, 1);
      check_eq($sformatf("t5_hold_dout_%0d", i), lane(dout, 0), 200);
      check_eq($sformatf("t5_hold_exp_%0d", i), sexp(blk_exp), 12);
      check_eq($sformatf("t5_hold_last_%0d", i), last_out, 0);
      check_eq($sformatf("t5_hold_rdyin_%0d", i), ready_in, 0);
      if (i < 3) step();
    end
    ready_out = 1'b1;
    for (int b = 1; b < BEATS; b++) begin
      check_eq($sformatf("t5_valid_b%0d", b), valid_out, 1);
      check_eq($sformatf("t5_dout_b%0d", b), lane(dout, 0), 100 * (b + 1));
      check_eq($sformatf("t5_last_b%0d", b), last_out, (b == BEATS - 1));
      step();
    end
    check_eq("t5_valid_after", valid_out, 0);
    check_eq("t5_rdyin_after", ready_in, 1);

    // Abort after two beats with a low count; next block must ignore it.
    clear_block(5);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 500, 0);
    send_block(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("t6_clr_valid", valid_out, 0);
    check_eq("t6_clr_rdyin", ready_in, 1);
    step();
    step();
    check_eq("t6_idle_valid", valid_out, 0);
    clear_block(12);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 1000, 1000);
    send_block(BEATS);
    recv_block("t6");

    // Asynchronous reset while draining.
    clear_block(12);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 300, 300);
    send_block(BEATS);
    check_eq("t7_valid_before", valid_out, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t7_rst_valid", valid_out, 0);
    check_eq("t7_rst_last", last_out, 0);
    check_eq("t7_rst_rdyin", ready_in, 0);
    check_eq("t7_rst_exp", sexp(blk_exp), 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    check_eq("t7_rel_rdyin", ready_in, 1);
    check_eq("t7_rel_valid", valid_out, 0);

    // Normal operation resumes after the reset.
    clear_block(11);
    for (int b = 0; b < BEATS; b++) set_lane(b, 0, 777, 389);
    send_block(BEATS);
    recv_block("t8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
